// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes, difficulty codes and lives width for the game-timing controller
package jogo_pkg;
   typedef enum logic [3:0] {
      EST_IDLE      = 4'd0,
      EST_PREPARA   = 4'd1,
      EST_RODANDO   = 4'd2,
      EST_CONGELADO = 4'd3,
      EST_VENCEU    = 4'd4,
      EST_PERDEU    = 4'd5
   } estado_t;
   localparam logic [1:0] MODO_FACIL   = 2'b00;
   localparam logic [1:0] MODO_MEDIO   = 2'b01;
   localparam logic [1:0] MODO_DIFICIL = 2'b10;
   localparam int VIDAS_W = 3;
endpackage

// File: rtl/contador_m_carga.sv
// contador_m_carga: clearable modulo counter whose modulus is an input; fim marks the last count
module contador_m_carga #(
   parameter int CNT_W = 27
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             limpa,
   input  logic             habilita,
   input  logic [CNT_W-1:0] modulo,
   output logic             fim
);
   logic [CNT_W-1:0] cnt_q;
   assign fim = cnt_q == modulo - CNT_W'(1);
   always_ff @(posedge clock) begin
      if (reset || limpa) cnt_q <= '0;
      else if (habilita) cnt_q <= fim ? '0 : cnt_q + CNT_W'(1);
   end
endmodule

// File: rtl/escalonador_jogo.sv
// escalonador_jogo: map scroll, movement enable, collision penalty/freeze and win/lose sequencing
module escalonador_jogo
   import jogo_pkg::*;
#(
   parameter int CNT_W           = 27,
   parameter int PERIODO_FACIL   = 50000000,
   parameter int PERIODO_MEDIO   = 25000000,
   parameter int PERIODO_DIFICIL = 12500000,
   parameter int PERIODO_FREEZE  = 100000000,
   parameter int VIDAS_MAX       = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic [1:0]         modo,
   input  logic               colisao,
   input  logic               fim_mapa,
   output logic               desloca_horizontal,
   output logic               habilita_movimento,
   output logic               perda_vida,
   output logic [VIDAS_W-1:0] vidas,
   output logic               venceu,
   output logic               perdeu,
   output logic [3:0]         db_estado
);
   estado_t            estado_q;
   logic [VIDAS_W-1:0] vidas_q;
   logic [CNT_W-1:0]   periodo_q;
   logic               perda_vida_q;
   logic               fim_cnt, limpa, ativo;
   // scroll period and freeze never overlap, so one counter serves both
   assign ativo = estado_q == EST_RODANDO || estado_q == EST_CONGELADO;
   assign limpa = !ativo || (estado_q == EST_RODANDO && colisao) || (estado_q == EST_CONGELADO && fim_cnt);
   contador_m_carga #(.CNT_W(CNT_W)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .limpa    (limpa),
      .habilita (ativo),
      .modulo   (estado_q == EST_CONGELADO ? CNT_W'(PERIODO_FREEZE) : periodo_q),
      .fim      (fim_cnt)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q     <= EST_IDLE;
         vidas_q      <= VIDAS_W'(VIDAS_MAX);
         periodo_q    <= CNT_W'(PERIODO_FACIL);
         perda_vida_q <= 1'b0;
      end else begin
         perda_vida_q <= 1'b0;
         case (estado_q)
            EST_IDLE: if (iniciar) estado_q <= EST_PREPARA;
            EST_PREPARA: begin
               periodo_q <= modo == MODO_FACIL ? CNT_W'(PERIODO_FACIL) :
                            modo == MODO_MEDIO ? CNT_W'(PERIODO_MEDIO) : CNT_W'(PERIODO_DIFICIL);
               vidas_q   <= VIDAS_W'(VIDAS_MAX);
               estado_q  <= EST_RODANDO;
            end
            EST_RODANDO: begin
               if (colisao) begin
                  vidas_q      <= vidas_q - VIDAS_W'(1);
                  perda_vida_q <= 1'b1;
                  estado_q     <= vidas_q > VIDAS_W'(1) ? EST_CONGELADO : EST_PERDEU;
               end else if (fim_mapa) estado_q <= EST_VENCEU;
            end
            EST_CONGELADO: if (fim_cnt) estado_q <= EST_RODANDO;
            EST_VENCEU, EST_PERDEU: if (iniciar) estado_q <= EST_PREPARA;
            default: estado_q <= EST_IDLE;
         endcase
      end
   end
   assign desloca_horizontal = estado_q == EST_RODANDO && fim_cnt;
   assign habilita_movimento = estado_q == EST_RODANDO;
   assign perda_vida         = perda_vida_q;
   assign vidas              = vidas_q;
   assign venceu             = estado_q == EST_VENCEU;
   assign perdeu             = estado_q == EST_PERDEU;
   assign db_estado          = estado_q;
endmodule

// File: doc/escalonador_jogo.md
Name: escalonador_jogo

Overview:
Game-timing controller for the drone simulator: sequences the obstacle map scroll, drone-move enable, collision penalty (life loss + freeze window) and win/lose detection. It drives desloca_horizontal and a movement enable into the datapath and consumes its colisao/fim_mapa flags. Period per difficulty mode is latched at game start. Sits beside the top-level FSM and offloads all timing from it.

Parameters:
CNT_W, 27, width of the shared period/freeze counter
PERIODO_FACIL, 50000000, clock cycles between map shifts in mode 00
PERIODO_MEDIO, 25000000, cycles between shifts in mode 01
PERIODO_DIFICIL, 12500000, cycles between shifts in modes 10 and 11
PERIODO_FREEZE, 100000000, cycles of freeze after a non-fatal collision
VIDAS_MAX, 3, lives at game start (1..7)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
iniciar  in  1  single-cycle start pulse (already edge-detected upstream)
modo  in  2  difficulty, sampled only in PREPARA
colisao  in  1  datapath collision flag, level
fim_mapa  in  1  datapath end-of-map flag, level
desloca_horizontal  out  1  one-cycle map-shift pulse
habilita_movimento  out  1  high while drone control is allowed
perda_vida  out  1  one-cycle pulse when a life is lost
vidas  out  3  remaining lives
venceu  out  1  level, game won
perdeu  out  1  level, game lost
db_estado  out  4  current state code

Behaviour:
- States/codes: IDLE 0, PREPARA 1, RODANDO 2, CONGELADO 3, VENCEU 4, PERDEU 5; other codes -> IDLE next cycle.
- Reset (any state, incl. mid-freeze): state IDLE, counter 0, vidas=VIDAS_MAX, all 1-bit outputs 0, db_estado 0.
- IDLE: iniciar -> PREPARA. Other inputs ignored.
- PREPARA (exactly 1 cycle): latch period from modo; vidas=VIDAS_MAX; counter 0; -> RODANDO.
- RODANDO: habilita_movimento=1. Counter 0 in first RODANDO cycle, +1 per cycle; desloca_horizontal is a Moore decode: high in the cycle cnt==P-1, then cnt wraps to 0. Period P = P cycles, pulse never two cycles wide.
- RODANDO input priority, same cycle: colisao > fim_mapa > count.
  - colisao with vidas>1: vidas-1, -> CONGELADO, counter 0, perda_vida=1 in first CONGELADO cycle.
  - colisao with vidas==1: vidas=0, -> PERDEU, perda_vida=1 in first PERDEU cycle.
  - fim_mapa (no colisao): -> VENCEU.
  - A desloca pulse already decoded in that cycle still issues; no pulse in the following cycle.
- CONGELADO: habilita_movimento=0, no desloca; colisao and fim_mapa ignored. Exactly PERIODO_FREEZE cycles, then -> RODANDO, counter 0.
- VENCEU/PERDEU: venceu/perdeu level held, habilita_movimento=0; vidas held; iniciar -> PREPARA (new game, modo re-sampled).
- iniciar in RODANDO/CONGELADO ignored. modo changes outside PREPARA ignored.
- All outputs registered or Moore-decoded from registers; no input-to-output combinational path.
- Counter: CNT_W bits, no overflow; each period parameter >=2 and < 2^CNT_W.

Decomposition:
- Package jogo_pkg: state codes, mode codes (FACIL 00, MEDIO 01, DIFICIL 10), vidas width.
- Sub-module contador_m_carga: loadable modulo counter (clear, enable, modulus input, fim flag) shared by scroll period and freeze, since the two are never active together.

Test Plan:
Params for bench: FACIL=4, MEDIO=3, DIFICIL=2, FREEZE=5, VIDAS_MAX=3.
1. reset, iniciar, modo=00 -> db_estado 1 for one cycle then 2; desloca high on RODANDO cycles 4,8,12 (1-indexed), each 1 cycle wide; vidas=3; habilita_movimento=1.
2. Start with modo=10, change modo to 00 mid-game -> desloca stays every 2 cycles.
3. colisao for 1 cycle in RODANDO -> next cycle db_estado 3, perda_vida=1 for 1 cycle, vidas=2; habilita 0 and no desloca for 5 cycles; colisao during freeze has no effect; then RODANDO with counter restarted.
4. Three spaced collisions -> after third: perdeu=1, vidas=0, db_estado 5; iniciar -> PREPARA, vidas=3, perdeu=0.
5. vidas=1, colisao and fim_mapa in the same cycle -> PERDEU; separate run with vidas=2 and fim_mapa alone -> venceu=1, vidas=2.
6. reset asserted in the 3rd CONGELADO cycle -> next cycle IDLE, all outputs 0, vidas=3; iniciar ignored until reset deasserts.
